riscv_pcgen: RTL and testbench

RISCV_PCGEN -- requirements
Module: riscv_pcgen

---
 rtl/riscv_pcgen_pkg.sv | 13 +
 rtl/riscv_ras.sv | 65 ++++++
 rtl/riscv_pcgen.sv | 120 ++++++++++++
 tb/tb_riscv_pcgen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pcgen_pkg.sv
// Shared definitions for the fetch PC generator: next-PC source selection.
package riscv_pcgen_pkg;

  // Listed from lowest to highest priority.
  typedef enum logic [2:0] {
    SEQ,
    RET,
    PEND,
    BR,
    TRAP
  } npc_sel_e;

endpackage

// File: rtl/riscv_ras.sv
// Circular return-address stack: push, pop, replace-top (push+pop) and clear.
module riscv_ras #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign top_idx = ptr_q - PW'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(RAS_DEPTH));

  // ptr_q is the next free slot; when full it also points at the oldest entry.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (push_i && pop_i) begin
      cnt_d = cnt_q;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (push_i && pop_i)
        mem_q[top_idx] <= wdata_i;
      else if (push_i)
        mem_q[ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/riscv_pcgen.sv
// Fetch PC generator: sequential/redirect/return selection, stall-time redirect capture, RAS.
module riscv_pcgen
  import riscv_pcgen_pkg::*;
#(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             i_riscv_pcgen_clk,
  input  logic             i_riscv_pcgen_rst_n,
  input  logic             i_riscv_pcgen_stallpc,
  input  logic             i_riscv_pcgen_instr_c,
  input  logic             i_riscv_pcgen_br_redir,
  input  logic [WIDTH-1:0] i_riscv_pcgen_br_target,
  input  logic             i_riscv_pcgen_trap_redir,
  input  logic [WIDTH-1:0] i_riscv_pcgen_trap_target,
  input  logic             i_riscv_pcgen_call,
  input  logic             i_riscv_pcgen_ret,
  output logic [WIDTH-1:0] o_riscv_pcgen_pc,
  output logic [WIDTH-1:0] o_riscv_pcgen_pc_plus,
  output logic             o_riscv_pcgen_ras_empty,
  output logic             o_riscv_pcgen_ras_full,
  output logic             o_riscv_pcgen_redir_pending
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_trap_q, pend_trap_d;
  logic [WIDTH-1:0] pc_plus, br_tgt, trap_tgt, ras_top;
  logic             ras_empty, ras_full, ras_push, ras_pop, ras_clear, ctl_free;
  npc_sel_e         sel;

  assign pc_plus  = pc_q + (i_riscv_pcgen_instr_c ? WIDTH'(2) : WIDTH'(4));
  assign br_tgt   = i_riscv_pcgen_br_target   & ~WIDTH'(1);
  assign trap_tgt = i_riscv_pcgen_trap_target & ~WIDTH'(1);

  assign ctl_free = !i_riscv_pcgen_stallpc && !i_riscv_pcgen_trap_redir
                    && !i_riscv_pcgen_br_redir && !pend_vld_q;

  always_comb begin
    sel = SEQ;
    if (i_riscv_pcgen_trap_redir)    sel = TRAP;
    else if (i_riscv_pcgen_br_redir) sel = BR;
    else if (pend_vld_q)             sel = PEND;
    else if (i_riscv_pcgen_ret && !ras_empty) sel = RET;
  end

  // While stalled, the pending slot keeps the highest-priority target seen so far.
  always_comb begin
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    if (i_riscv_pcgen_stallpc) begin
      if (i_riscv_pcgen_trap_redir) begin
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b1;
        pend_tgt_d  = trap_tgt;
      end else if (i_riscv_pcgen_br_redir && !(pend_vld_q && pend_trap_q)) begin
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b0;
        pend_tgt_d  = br_tgt;
      end
    end else begin
      pend_vld_d  = 1'b0;
      pend_trap_d = 1'b0;
      unique case (sel)
        TRAP:    pc_d = trap_tgt;
        BR:      pc_d = br_tgt;
        PEND:    pc_d = pend_tgt_q;
        RET:     pc_d = ras_top;
        default: pc_d = pc_plus;
      endcase
    end
  end

  always_comb begin
    ras_push  = ctl_free && i_riscv_pcgen_call;
    ras_pop   = ctl_free && i_riscv_pcgen_ret && !ras_empty;
    ras_clear = !i_riscv_pcgen_stallpc
                && ((sel == TRAP) || ((sel == PEND) && pend_trap_q));
  end

  always_ff @(posedge i_riscv_pcgen_clk or negedge i_riscv_pcgen_rst_n) begin
    if (!i_riscv_pcgen_rst_n) begin
      pc_q        <= RESET_VECTOR;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  riscv_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (i_riscv_pcgen_clk),
    .rst_ni  (i_riscv_pcgen_rst_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .clear_i (ras_clear),
    .wdata_i (pc_plus),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  assign o_riscv_pcgen_pc            = pc_q;
  assign o_riscv_pcgen_pc_plus       = pc_plus;
  assign o_riscv_pcgen_ras_empty     = ras_empty;
  assign o_riscv_pcgen_ras_full      = ras_full;
  assign o_riscv_pcgen_redir_pending = pend_vld_q;

endmodule

// File: tb/tb_riscv_pcgen.sv
// Self-checking bench for riscv_pcgen: directed vector table, async reset case, random vs. reference model.
module tb_riscv_pcgen;

  localparam int unsigned W = 64;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, instr_c, br, trap, call, ret;
  logic [W-1:0]  bt, tt;
  logic [W-1:0]  pc, pc_plus;
  logic          ras_empty, ras_full, pend;

  always #5 clk = ~clk;

  riscv_pcgen #(
    .WIDTH        (W),
    .RESET_VECTOR (64'h0),
    .RAS_DEPTH    (D)
  ) dut (
    .i_riscv_pcgen_clk           (clk),
    .i_riscv_pcgen_rst_n         (rst_n),
    .i_riscv_pcgen_stallpc       (stall),
    .i_riscv_pcgen_instr_c       (instr_c),
    .i_riscv_pcgen_br_redir      (br),
    .i_riscv_pcgen_br_target     (bt),
    .i_riscv_pcgen_trap_redir    (trap),
    .i_riscv_pcgen_trap_target   (tt),
    .i_riscv_pcgen_call          (call),
    .i_riscv_pcgen_ret           (ret),
    .o_riscv_pcgen_pc            (pc),
    .o_riscv_pcgen_pc_plus       (pc_plus),
    .o_riscv_pcgen_ras_empty     (ras_empty),
    .o_riscv_pcgen_ras_full      (ras_full),
    .o_riscv_pcgen_redir_pending (pend)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           st, c, br, tr, call, ret;
    logic [W-1:0] bt, tt;
    logic [W-1:0] pc;
    bit           pend, emp, full;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit st, input bit c, input bit b, input logic [W-1:0] btv,
                     input bit t, input logic [W-1:0] ttv, input bit cl, input bit rt,
                     input logic [W-1:0] epc, input bit ep, input bit ee, input bit ef);
    vec_t v;
    v.st = st; v.c = c; v.br = b; v.bt = btv; v.tr = t; v.tt = ttv;
    v.call = cl; v.ret = rt; v.pc = epc; v.pend = ep; v.emp = ee; v.full = ef;
    tbl.push_back(v);
  endtask

  // Reference model: RAS as a bounded queue, pending redirect as target + priority.
  logic [W-1:0] m_pc;
  bit           m_pv;
  int           m_pri;
  logic [W-1:0] m_pt;
  logic [W-1:0] m_ras[$];

  task automatic model_reset();
    m_pc = '0; m_pv = 0; m_pri = 0; m_pt = '0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] plus;
    plus = m_pc + (instr_c ? 64'd2 : 64'd4);
    if (stall) begin
      if (trap) begin
        m_pv = 1; m_pri = 2; m_pt = tt & ~64'd1;
      end else if (br && !(m_pv && m_pri == 2)) begin
        m_pv = 1; m_pri = 1; m_pt = bt & ~64'd1;
      end
    end else begin
      if (trap) begin
        m_pc = tt & ~64'd1;
        m_ras.delete();
      end else if (br) begin
        m_pc = bt & ~64'd1;
      end else if (m_pv) begin
        m_pc = m_pt;
        if (m_pri == 2) m_ras.delete();
      end else if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        if (call) m_ras.push_back(plus);
      end else begin
        m_pc = plus;
        if (call) begin
          m_ras.push_back(plus);
          if (m_ras.size() > D) void'(m_ras.pop_front());
        end
      end
      m_pv = 0;
    end
  endtask

  task automatic check_model();
    cmp("rnd_pc", pc, m_pc);
    cmp("rnd_pc_plus", pc_plus, m_pc + (instr_c ? 64'd2 : 64'd4));
    cmp("rnd_pending", W'(pend), W'(m_pv));
    cmp("rnd_empty", W'(ras_empty), W'(m_ras.size() == 0));
    cmp("rnd_full", W'(ras_full), W'(m_ras.size() == D));
  endtask

  task automatic idle_inputs();
    stall = 0; instr_c = 0; br = 0; trap = 0; call = 0; ret = 0; bt = '0; tt = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    //       st c  br bt        tr tt        cl rt  pc         pend emp full
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h4,   0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h8,   0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'hC,   0, 1, 0);
    row(0, 0, 1, 64'h8,   0, 64'h0,   0, 0, 64'h8,   0, 1, 0);
    row(0, 1, 0, 64'h0,   0, 64'h0,   0, 0, 64'hA,   0, 1, 0);
    row(1, 0, 1, 64'h101, 0, 64'h0,   0, 0, 64'hA,   1, 1, 0);
    row(1, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'hA,   1, 1, 0);
    row(1, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'hA,   1, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h100, 0, 1, 0);
    row(1, 0, 0, 64'h0,   1, 64'h200, 0, 0, 64'h100, 1, 1, 0);
    row(1, 0, 1, 64'h300, 0, 64'h0,   0, 0, 64'h100, 1, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h200, 0, 1, 0);
    row(0, 0, 1, 64'h100, 0, 64'h0,   0, 0, 64'h100, 0, 1, 0);
    row(1, 0, 1, 64'h300, 0, 64'h0,   0, 0, 64'h100, 1, 1, 0);
    row(1, 0, 0, 64'h0,   1, 64'h200, 0, 0, 64'h100, 1, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 64'h200, 0, 1, 0);
    row(0, 0, 1, 64'h10,  0, 64'h0,   0, 0, 64'h10,  0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h14,  0, 0, 0);
    row(0, 0, 1, 64'h20,  0, 64'h0,   0, 0, 64'h20,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h24,  0, 0, 0);
    row(0, 0, 1, 64'h30,  0, 64'h0,   0, 0, 64'h30,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h34,  0, 0, 0);
    row(0, 0, 1, 64'h40,  0, 64'h0,   0, 0, 64'h40,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h44,  0, 0, 1);
    row(0, 0, 1, 64'h50,  0, 64'h0,   0, 0, 64'h50,  0, 0, 1);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h54,  0, 0, 1);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h54,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h44,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h34,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h24,  0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h28,  0, 1, 0);
    row(0, 0, 1, 64'h10,  0, 64'h0,   0, 0, 64'h10,  0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h14,  0, 0, 0);
    row(0, 0, 1, 64'h20,  0, 64'h0,   0, 0, 64'h20,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h24,  0, 0, 0);
    row(0, 0, 1, 64'h80,  0, 64'h0,   0, 0, 64'h80,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 1, 64'h24,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h84,  0, 0, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h14,  0, 1, 0);
    row(0, 0, 1, 64'h10,  0, 64'h0,   0, 0, 64'h10,  0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h14,  0, 0, 0);
    row(0, 0, 0, 64'h0,   1, 64'h401, 0, 0, 64'h400, 0, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h404, 0, 1, 0);
    row(1, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h404, 0, 1, 0);
    row(0, 0, 1, 64'h500, 0, 64'h0,   1, 0, 64'h500, 0, 1, 0);
    row(1, 0, 1, 64'h600, 0, 64'h0,   0, 0, 64'h500, 1, 1, 0);
    row(0, 0, 0, 64'h0,   0, 64'h0,   1, 0, 64'h600, 0, 1, 0);

    repeat (2) @(negedge clk);
    cmp("reset_pc", pc, 64'h0);
    cmp("reset_pending", W'(pend), 64'h0);
    cmp("reset_empty", W'(ras_empty), 64'h1);
    cmp("reset_full", W'(ras_full), 64'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      stall = tbl[i].st; instr_c = tbl[i].c; br = tbl[i].br; bt = tbl[i].bt;
      trap = tbl[i].tr; tt = tbl[i].tt; call = tbl[i].call; ret = tbl[i].ret;
      @(posedge clk); #1;
      cmp($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      cmp($sformatf("tbl%0d_pc_plus", i), pc_plus, tbl[i].pc + (tbl[i].c ? 64'd2 : 64'd4));
      cmp($sformatf("tbl%0d_pending", i), W'(pend), W'(tbl[i].pend));
      cmp($sformatf("tbl%0d_empty", i), W'(ras_empty), W'(tbl[i].emp));
      cmp($sformatf("tbl%0d_full", i), W'(ras_full), W'(tbl[i].full));
      @(negedge clk);
    end

    // Asynchronous reset between edges while a redirect is pending and the RAS is non-empty.
    idle_inputs();
    call = 1;
    @(posedge clk); #1;
    cmp("arst_setup_pc", pc, 64'h604);
    cmp("arst_setup_empty", W'(ras_empty), 64'h0);
    @(negedge clk);
    idle_inputs();
    stall = 1; br = 1; bt = 64'h555;
    @(posedge clk); #1;
    cmp("arst_setup_pending", W'(pend), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_pc", pc, 64'h0);
    cmp("arst_pending", W'(pend), 64'h0);
    cmp("arst_empty", W'(ras_empty), 64'h1);
    cmp("arst_full", W'(ras_full), 64'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      stall   = ($urandom_range(0, 99) < 30);
      instr_c = $urandom_range(0, 1) == 1;
      br      = ($urandom_range(0, 99) < 10);
      trap    = ($urandom_range(0, 99) < 4);
      call    = ($urandom_range(0, 99) < 25);
      ret     = ($urandom_range(0, 99) < 25);
      bt      = {$urandom, $urandom};
      tt      = {$urandom, $urandom};
      model_step();
      @(posedge clk); #1;
      check_model();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
